// File: rtl/muldiv_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encoding and the default width.
package muldiv_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCalc  = 2'd1,
        StFixup = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational sign handling: operand magnitudes at accept time, and
// two's-complement correction plus result word selection at fixup time.
module muldiv_sign_fix
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [2:0]        op,
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,
    output logic [XLEN-1:0]   mag1,
    output logic [XLEN-1:0]   mag2,
    output logic              neg_res,
    output logic              neg_rem,
    input  logic [2:0]        fix_op,
    input  logic              fix_neg_res,
    input  logic              fix_neg_rem,
    input  logic [2*XLEN-1:0] raw,
    output logic [XLEN-1:0]   fixed_result
);

    logic              s1;
    logic              s2;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;

    always_comb begin
        s1 = rs1[XLEN-1] && (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        s2 = rs2[XLEN-1] && (op == OP_MULH || op == OP_DIV || op == OP_REM);
        // Negating the most negative value yields itself, read back as unsigned.
        mag1    = s1 ? -rs1 : rs1;
        mag2    = s2 ? -rs2 : rs2;
        neg_res = s1 ^ s2;
        neg_rem = s1;
    end

    always_comb begin
        prod = fix_neg_res ? -raw : raw;
        quot = fix_neg_res ? -raw[XLEN-1:0] : raw[XLEN-1:0];
        rem  = fix_neg_rem ? -raw[2*XLEN-1:XLEN] : raw[2*XLEN-1:XLEN];
        fixed_result = rem;
        case (fix_op)
            OP_MUL:                       fixed_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fixed_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fixed_result = quot;
            default:                      fixed_result = rem;
        endcase
    end

endmodule

// File: rtl/muldiv_iterative.sv
// Bit-serial RV32M multiply/divide with valid/ready request and response
// channels; one iteration per cycle, flushable from the pipeline.
module muldiv_iterative
    import muldiv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN + 1;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic            neg_res_q, neg_res_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] mag1, mag2, fixed_result;
    logic            neg_res, neg_rem;
    logic            accept, div_zero, div_ovf;
    logic [XLEN:0]   mul_sum, rem_up, rem_diff;
    logic [AW-1:0]   mul_step, div_step, shifted;

    muldiv_sign_fix #(
        .XLEN(XLEN)
    ) u_sign_fix (
        .op           (req_op),
        .rs1          (rs1),
        .rs2          (rs2),
        .mag1         (mag1),
        .mag2         (mag2),
        .neg_res      (neg_res),
        .neg_rem      (neg_rem),
        .fix_op       (op_q),
        .fix_neg_res  (neg_res_q),
        .fix_neg_rem  (neg_rem_q),
        .raw          (acc_q[2*XLEN-1:0]),
        .fixed_result (fixed_result)
    );

    always_comb begin
        // Shift-add: conditionally add multiplicand into the upper half, then shift right.
        mul_sum  = acc_q[AW-1:XLEN] + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_step = {1'b0, mul_sum, acc_q[XLEN-1:1]};
        // Restoring division: shift left, keep the trial subtraction if it did not borrow.
        shifted  = {acc_q[AW-2:0], 1'b0};
        rem_up   = shifted[AW-1:XLEN];
        rem_diff = rem_up - {1'b0, opb_q};
        div_step = shifted;
        if (rem_up >= {1'b0, opb_q}) begin
            div_step[AW-1:XLEN] = rem_diff;
            div_step[0]         = 1'b1;
        end
    end

    always_comb begin
        accept   = req_valid && (state_q == StIdle) && !flush;
        div_zero = req_op[2] && (rs2 == '0);
        div_ovf  = (req_op == OP_DIV || req_op == OP_REM) &&
                   (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        opb_d     = opb_q;
        acc_d     = acc_q;
        count_d   = count_q;
        result_d  = result_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d      = req_op;
                    neg_res_d = neg_res;
                    neg_rem_d = neg_rem;
                    count_d   = '0;
                    if (div_zero) begin
                        result_d = req_op[1] ? rs1 : '1;
                        state_d  = StDone;
                    end else if (div_ovf) begin
                        result_d = req_op[1] ? '0 : rs1;
                        state_d  = StDone;
                    end else begin
                        acc_d   = {{(XLEN+1){1'b0}}, req_op[2] ? mag1 : mag2};
                        opb_d   = req_op[2] ? mag2 : mag1;
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d   = op_q[2] ? div_step : mul_step;
                count_d = count_q + 1'b1;
                if (count_q == CW'(XLEN - 1)) begin
                    state_d = StFixup;
                end
            end
            StFixup: begin
                result_d = fixed_result;
                state_d  = StDone;
            end
            StDone: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            opb_q     <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            opb_q     <= opb_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            result_q  <= result_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = (state_q == StDone);
    assign busy       = (state_q == StCalc) || (state_q == StFixup);
    assign result     = result_q;

endmodule

// File: tb/tb_muldiv_iterative.sv
// Self-checking bench for muldiv_iterative: directed vector table, corner
// sequences (backpressure, flush, reset) and random ops against a reference model.
module tb_muldiv_iterative;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    muldiv_iterative dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .rs1        (rs1),
        .rs2        (rs2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .result     (result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] p;
        int sa;
        int sb;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: p = $signed({32'b0, a}) * $signed({32'b0, b});
            3'd1: p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            3'd2: p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
            3'd3: p = $signed({32'b0, a}) * $signed({32'b0, b});
            default: p = '0;
        endcase
        case (op)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Caller is #1 after a rising edge. Returns result and accept-to-valid latency.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] res, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
        if (!req_ready) check("req_ready wait", req_ready, 1'b1);
        req_valid  = 1'b1;
        req_op     = op;
        rs1        = a;
        rs2        = b;
        resp_ready = (hold == 0);
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 200) begin
            step();
            lat++;
        end
        res = result;
        if (hold > 0) begin
            for (int k = 0; k < hold; k++) begin
                check("hold resp_valid", resp_valid, 1'b1);
                check("hold req_ready", req_ready, 1'b0);
                check("hold result", result, res);
                step();
            end
            resp_ready = 1'b1;
            step();
            check("post-accept resp_valid", resp_valid, 1'b0);
            check("post-accept req_ready", req_ready, 1'b1);
        end else begin
            step();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        int          lat;
        logic        seen;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 1};

        reset      = 1'b1;
        flush      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        rs1        = '0;
        rs2        = '0;
        resp_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        check("reset req_ready", req_ready, 1'b1);
        check("reset resp_valid", resp_valid, 1'b0);
        check("reset result", result, 32'd0);
        check("reset busy", busy, 1'b0);

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, res, lat);
            check($sformatf("vec%0d result", i), res, vecs[i].exp);
            check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
        end

        // Backpressure: five cycles of resp_ready low, accept on the sixth.
        run_op(3'd0, 32'd3, 32'd5, 5, res, lat);
        check("bp result", res, 32'd15);
        check("bp latency", lat, 34);

        // Flush with a request pending in IDLE must not accept it.
        req_valid = 1'b1;
        req_op    = 3'd5;
        rs1       = 32'd9;
        rs2       = 32'd3;
        flush     = 1'b1;
        step();
        req_valid = 1'b0;
        flush     = 1'b0;
        check("idle flush busy", busy, 1'b0);
        check("idle flush req_ready", req_ready, 1'b1);

        // Flush at CALC count 10.
        req_valid = 1'b1;
        req_op    = 3'd5;
        rs1       = 32'hFFFF_FFFF;
        rs2       = 32'd3;
        step();
        req_valid = 1'b0;
        repeat (10) step();
        check("calc busy", busy, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush req_ready", req_ready, 1'b1);
        check("flush busy", busy, 1'b0);
        check("flush resp_valid", resp_valid, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid) seen = 1'b1;
            step();
        end
        check("flush no response", seen, 1'b0);
        run_op(3'd5, 32'd9, 32'd3, 0, res, lat);
        check("after flush result", res, 32'd3);
        check("after flush latency", lat, 34);

        // Reset mid-CALC.
        req_valid = 1'b1;
        req_op    = 3'd0;
        rs1       = 32'd11;
        rs2       = 32'd13;
        step();
        req_valid = 1'b0;
        repeat (6) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid reset req_ready", req_ready, 1'b1);
        check("mid reset resp_valid", resp_valid, 1'b0);
        check("mid reset result", result, 32'd0);
        check("mid reset busy", busy, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (resp_valid) seen = 1'b1;
            step();
        end
        check("mid reset no response", seen, 1'b0);

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            run_op(op, a, b, 0, res, lat);
            check($sformatf("rand%0d op%0d %h,%h result", i, op, a, b), res, ref_model(op, a, b));
            check($sformatf("rand%0d latency", i), lat, ref_latency(op, a, b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
